pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 101 ++++++++++
 tb/tb_pipe_adder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Segmented carry-pipelined adder/subtractor with a valid/ready handshake.
// A stall at the output freezes the whole pipeline, so every stage shares a single advance enable.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           c);
    return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
  endfunction

  logic adv;

  assign adv = in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, sum_in, sum_d;
    logic             c_in, sub_in, vld_in;
    logic [SEG:0]     seg;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             c_q, sub_q, vld_q;

    // Subtraction is folded in at the head: B and the carry-in are inverted once.
    if (k == 0) begin : g_head
      assign a_in   = i0;
      assign b_in   = sub ? ~i1 : i1;
      assign c_in   = ci ^ sub;
      assign sum_in = '0;
      assign sub_in = sub;
      assign vld_in = in_valid && in_ready;
    end else begin : g_body
      assign a_in   = g_stage[k-1].a_q;
      assign b_in   = g_stage[k-1].b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign sum_in = g_stage[k-1].sum_q;
      assign sub_in = g_stage[k-1].sub_q;
      assign vld_in = g_stage[k-1].vld_q;
    end

    always_comb begin
      seg                    = seg_add(a_in[k*SEG +: SEG], b_in[k*SEG +: SEG], c_in);
      sum_d                  = sum_in;
      sum_d[k*SEG +: SEG]    = seg[SEG-1:0];
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (adv) begin
        a_q   <= a_in;
        b_q   <= b_in;
        sum_q <= sum_d;
        c_q   <= seg[SEG];
        sub_q <= sub_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q <= vld_in;
      end
    end
  end

  assign out_valid = g_stage[LAST].vld_q;
  assign in_ready  = out_ready || !out_valid;

  // Results are gated by out_valid so the outputs read zero whenever nothing is held.
  always_comb begin
    s   = '0;
    co  = 1'b0;
    ovf = 1'b0;
    if (out_valid) begin
      s   = g_stage[LAST].sum_q;
      co  = g_stage[LAST].c_q ^ g_stage[LAST].sub_q;
      ovf = (g_stage[LAST].a_q[WIDTH-1] == g_stage[LAST].b_q[WIDTH-1]) &&
            (g_stage[LAST].sum_q[WIDTH-1] != g_stage[LAST].a_q[WIDTH-1]);
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: four 8-bit instances (1, 2, 4 and 8 stages) share one stimulus stream,
// each scored against an arithmetic reference queue; the 2-stage one also gets directed literal checks.
module tb_pipe_adder;

  typedef struct {
    logic [9:0] exp;
    int         cyc;
    int         stl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] i0 = '0;
  logic [7:0] i1 = '0;
  logic       ci = 1'b0;
  logic       sub = 1'b0;

  logic       in_ready_w  [4];
  logic       out_valid_w [4];
  logic [7:0] s_w         [4];
  logic       co_w        [4];
  logic       ovf_w       [4];
  int         pend        [4];
  int         xfer        [4];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: {ovf, co, s} from plain integer arithmetic.
  function automatic logic [9:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic sb);
    int ua, ub, sa, sbv, cc, r, sr;
    logic [7:0] rs;
    logic rco, rov;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    cc  = c ? 1 : 0;
    if (!sb) begin
      r   = ua + ub + cc;
      sr  = sa + sbv + cc;
      rco = (r > 255);
    end else begin
      r   = ua - ub - cc;
      sr  = sa - sbv - cc;
      rco = (r < 0);
    end
    rs  = r[7:0];
    rov = (sr > 127) || (sr < -128);
    return {rov, rco, rs};
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int ST = 1 << gi;

    pipe_adder #(.WIDTH(8), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .i0        (i0),
      .i1        (i1),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready),
      .s         (s_w[gi]),
      .co        (co_w[gi]),
      .ovf       (ovf_w[gi])
    );

    exp_t       q[$];
    exp_t       e;
    int         cyc = 0;
    int         stl = 0;
    logic       pstall = 1'b0;
    logic [9:0] prev = '0;
    logic [9:0] act;

    initial begin
      pend[gi] = 0;
      xfer[gi] = 0;
    end

    always @(negedge clk) begin
      act = {ovf_w[gi], co_w[gi], s_w[gi]};
      if (!rst_n) begin
        q.delete();
        pstall = 1'b0;
        check($sformatf("st%0d_reset_clear", ST), {out_valid_w[gi], act}, 32'h0);
      end else begin
        check($sformatf("st%0d_in_ready", ST), in_ready_w[gi], out_ready || !out_valid_w[gi]);
        if (pstall)
          check($sformatf("st%0d_stall_hold", ST), {out_valid_w[gi], act}, {1'b1, prev});
        if (out_valid_w[gi]) begin
          if (q.size() == 0) begin
            check($sformatf("st%0d_spurious_out", ST), out_valid_w[gi], 1'b0);
          end else begin
            e = q[0];
            check($sformatf("st%0d_result", ST), act, e.exp);
            if (out_ready) begin
              if (e.stl == stl) check($sformatf("st%0d_latency", ST), cyc - e.cyc, ST);
              void'(q.pop_front());
              xfer[gi]++;
            end
          end
        end
        if (out_valid_w[gi] && !out_ready) stl++;
        pstall = out_valid_w[gi] && !out_ready;
        prev   = act;
        if (in_valid && in_ready_w[gi])
          q.push_back('{exp: ref_res(i0, i1, ci, sub), cyc: cyc, stl: stl});
      end
      pend[gi] = q.size();
      cyc++;
    end
  end

  // Present one operand set and hold it until the 2-stage instance accepts it.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb);
    int   guard;
    logic ok;
    i0 = a; i1 = b; ci = c; sub = sb; in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      ok = in_ready_w[1];
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) check("drive_timeout", 32'd0, 32'd1);
  endtask

  task automatic lit(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic sb, input logic [7:0] es,
                     input logic eco, input logic eov);
    drive_op(a, b, c, sb);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_valid"}, out_valid_w[1], 1'b1);
    check({name, "_s"},     s_w[1],         es);
    check({name, "_co"},    co_w[1],        eco);
    check({name, "_ovf"},   ovf_w[1],       eov);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         x0;
    logic [9:0] snap;
    int         guard;

    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid_w[1], 1'b0);
    check("reset_outputs",   {ovf_w[1], co_w[1], s_w[1]}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("release_in_ready", in_ready_w[1], 1'b1);
    @(posedge clk);
    #1;

    lit("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    lit("add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    lit("sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    lit("sub_05_07",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
    lit("sub_05_02b", 8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    lit("add_7f_00c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);

    // Four back-to-back sets with a three-cycle output stall once the first result shows.
    repeat (4) @(posedge clk);
    #1;
    x0 = xfer[1];
    fork
      begin
        drive_op(8'h10, 8'h20, 1'b0, 1'b0);
        drive_op(8'h50, 8'h10, 1'b0, 1'b1);
        drive_op(8'h01, 8'h02, 1'b1, 1'b0);
        drive_op(8'hF0, 8'h20, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        guard = 0;
        while (!out_valid_w[1] && guard < 20) begin
          @(posedge clk);
          #1;
          guard++;
        end
        check("stall_first_seen", out_valid_w[1], 1'b1);
        out_ready = 1'b0;
        snap = {ovf_w[1], co_w[1], s_w[1]};
        check("stall_first_value", snap, 10'h030);
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready_w[1], 1'b0);
          check("stall_frozen", {out_valid_w[1], ovf_w[1], co_w[1], s_w[1]}, {1'b1, snap});
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1 check("stream_count", xfer[1] - x0, 4);

    // Reset with two sets in flight.
    drive_op(8'h11, 8'h22, 1'b0, 1'b0);
    drive_op(8'h33, 8'h44, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid_w[1], 1'b0);
    check("midrst_outputs",   {ovf_w[1], co_w[1], s_w[1]}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("midrst_release_ready", in_ready_w[1], 1'b1);
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid_w[1], 1'b0);
    end

    // Random traffic: free-flowing first, then with random back-pressure.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (n < 200) ? 1'b1 : ($urandom_range(0, 4) != 0);
      i0        = 8'($urandom_range(0, 255));
      i1        = 8'($urandom_range(0, 255));
      ci        = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_empty_%0d", i), pend[i], 0);
      check($sformatf("traffic_seen_%0d", i), xfer[i] > 100, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
